rgb_led_arbiter: RTL and testbench
==================================

# rgb_led_arbiter

Shares the on-board active-low RGB LED between `NUM_REQ` status sources. Each source requests the LED with a 3-bit color and a dwell time in ticks. The block grants requests round-robin, drives the LED for exactly the requested dwell, inserts a blank gap, and then moves to the next requester. It sits between status-producing blocks (color cyclers, error flags, heartbeat) and the `RGB_R/G/B` pins.

## Interface
- `NUM_REQ`, 4: number of requesters; range 2–8.
- `TICK_CYCLES`, 12000: clk cycles per dwell tick (1 ms at 12 MHz).
- `DUR_W`, 10: width of each dwell field, in ticks.
- `GAP_CYCLES`, 120000: LED-off cycles between grants (10 ms); must be ≥1.

Ports:
- `clk` in 1: 12 MHz system clock.
- `reset` in 1: synchronous, active-high.
- `req` in `NUM_REQ`: level request, one bit per source.
- `color` in `3*NUM_REQ`: per-source {R,G,B}, active-high; source i occupies `[3i+2:3i]`.
- `dur` in `DUR_W*NUM_REQ`: per-source dwell in ticks.
- `grant` out `NUM_REQ`: one-hot; high for the whole SHOW of the granted source.
- `done` out `NUM_REQ`: one-cycle pulse when a dwell completes normally.
- `busy` out 1: high in SHOW and GAP.
- `RGB_R`, `RGB_G`, `RGB_B` out 1 each: LED drives, active-low (0 = lit).

## Operation
- **States:** IDLE, SHOW, GAP.
- **Reset:** state=IDLE, `grant`=0, `done`=0, `busy`=0, `RGB_*`=1 (all off), RR pointer=0 (source 0 has highest priority), counters=0.
- **IDLE:** if any `req` is high, pick the first requesting index at or after the pointer, wrapping.
  - Latch that source's `color` and `dur`, set its `grant` bit, and set the pointer to index+1 mod `NUM_REQ`.
  - Go to SHOW. If no request, stay in IDLE.
- **SHOW:** the LED shows the latched color. The latched values are unaffected by later input changes.
  - Tick counter and dwell counter restart at grant.
  - Normal end: after `dur*TICK_CYCLES` SHOW cycles, pulse `done[i]`, clear `grant`, and go to GAP.
  - `dur`=0: SHOW lasts exactly one cycle with LED off; `done` pulses as normal.
  - Abort: if `req[i]` is sampled low during SHOW, clear `grant` and go to GAP the next cycle with no `done`.
  - Abort takes precedence if it coincides with the final dwell cycle.
- **GAP:** LED off for `GAP_CYCLES` cycles, then go to IDLE. New requests are only arbitrated in IDLE.
- **Widths:**
  - Tick counter: `$clog2(TICK_CYCLES)` bits, wraps at `TICK_CYCLES-1`.
  - Dwell counter: `DUR_W` bits, counts up and compares to the latched `dur`. It must not overflow at `dur` = 2^`DUR_W`−1.
  - Gap counter: `$clog2(GAP_CYCLES+1)` bits.
- A requester that keeps `req` high is re-granted only after every other pending requester has been served once.

## Timing
- `req` high in IDLE at edge N → `grant`, `busy`, and LED valid from edge N+1. Arbitration is registered with no combinational path from `req` to outputs.
- For SHOW entered at edge N+1 with `dur`=D≥1:
  - LED lit for exactly D·`TICK_CYCLES` cycles.
  - `done` is high in cycle N+1+D·`TICK_CYCLES`, the same cycle GAP begins.
- GAP lasts `GAP_CYCLES` cycles. `busy` falls on the first IDLE cycle.
- The earliest next grant is one cycle after entering IDLE.
- `reset` asserted in any state: the next edge forces reset values, with no `done` pulse. Any in-flight dwell is discarded.

## Structure
- Package `rgb_led_pkg`:
  - `state_t` enum {IDLE, SHOW, GAP}.
  - `rgb_t` typedef as a 3-bit packed {r,g,b}.
  - `LED_OFF` constant 3'b111 (active-low).
- Sub-module `rr_arbiter` (parameter `N`):
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, `valid`.
  - Purely combinational; the pointer register stays in the top.
- Top contains the FSM, the three counters, and the color/dwell latches.

## Test plan
Benches use `TICK_CYCLES`=4, `GAP_CYCLES`=3, `NUM_REQ`=4.
- **Reset:** release reset with no requests → `RGB_*`=111, `grant`=0, `busy`=0, and these hold for 50 cycles.
- **Single request:** `req`=0001, `color0`=3'b110, `dur0`=2 → `grant`=0001 for 8 cycles, RGB=001 (R,G lit), `done[0]` pulses once, then 3 off cycles.
- **Round-robin:** `req`=1111 held, all `dur`=1 → grants in order 0,1,2,3,0, each 4 cycles, separated by 3-cycle gaps.
- **Abort:** `req0` dropped 2 cycles into a `dur`=3 SHOW → `grant` clears on the next edge, no `done`, GAP follows, and `req1` is granted after the gap.
- **Edge values:**
  - `dur`=0 → one SHOW cycle with LED off, then `done`.
  - `dur`=1023 → `done` exactly 4092 cycles after grant.
- **Mid-SHOW reset:** assert `reset` mid-SHOW → next cycle is IDLE with all outputs at reset values and the RR pointer at 0.

Source files
------------

// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg: shared types and constants for the RGB LED arbiter.
//   state_t   : arbiter FSM states (IDLE, SHOW, GAP)
//   rgb_t     : active-high color, packed {r,g,b}
//   LED_OFF   : pin pattern with all three active-low LED drives off
//   led_drive : converts an active-high color into active-low pin levels
package rgb_led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  localparam logic [2:0] LED_OFF = 3'b111;

  // The LED pins sink current, so a lit channel is a low pin.
  function automatic logic [2:0] led_drive(input rgb_t c);
    return ~{c.r, c.g, c.b};
  endfunction

endpackage

// File: rtl/rgb_led_if.sv
// rgb_led_if: request/grant bundle between the status sources and the
// LED arbiter, plus the LED pin drives.
//   req   : level request, one bit per source
//   color : per-source {R,G,B}, source i at [3i+2:3i]
//   dur   : per-source dwell in ticks, source i at [DUR_W*i +: DUR_W]
//   grant : one-hot owner of the LED during SHOW
//   done  : one-cycle pulse when a dwell completes normally
//   busy  : high while showing or in the blank gap
//   RGB_R/RGB_G/RGB_B : active-low LED pins
// master = the requesting side, slave = the arbiter.
interface rgb_led_if #(
  parameter int NUM_REQ = 4,
  parameter int DUR_W   = 10
);
  logic [NUM_REQ-1:0]       req;
  logic [3*NUM_REQ-1:0]     color;
  logic [DUR_W*NUM_REQ-1:0] dur;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic                     RGB_R;
  logic                     RGB_G;
  logic                     RGB_B;

  modport master (
    output req, color, dur,
    input  grant, done, busy, RGB_R, RGB_G, RGB_B
  );

  modport slave (
    input  req, color, dur,
    output grant, done, busy, RGB_R, RGB_G, RGB_B
  );
endinterface

// File: rtl/rgb_led_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req_i   : request vector
//   ptr_i   : index holding highest priority this round
//   gnt_o   : one-hot grant of the first requester at or after ptr_i (wrapping)
//   valid_o : at least one request was present
// The priority pointer register lives in the instantiating module.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          valid_o
);

  // Walk the sources starting at the pointer; the first hit wins.
  always_comb begin
    int   idx;
    logic hit;
    idx     = 0;
    hit     = 1'b0;
    gnt_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx        = (int'(ptr_i) + k) % N;
      hit        = req_i[idx] & ~valid_o;
      gnt_o[idx] = gnt_o[idx] | hit;
      valid_o    = valid_o | hit;
    end
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// rgb_led_arbiter: shares one active-low RGB LED between NUM_REQ sources.
// Requests are granted round-robin; the granted color is shown for
// dur*TICK_CYCLES cycles, then the LED is blanked for GAP_CYCLES cycles
// before the next arbitration.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : rgb_led_if slave modport (req/color/dur in, grant/done/busy/RGB out)
module rgb_led_arbiter
  import rgb_led_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TICK_CYCLES = 12000,
  parameter int DUR_W       = 10,
  parameter int GAP_CYCLES  = 120000
) (
  input logic        clk,
  input logic        reset,
  rgb_led_if.slave   bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  state_t               state_q;
  logic [PW-1:0]        ptr_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic                 busy_q;
  logic [2:0]           rgb_q;
  rgb_t                 color_q;
  logic [DUR_W-1:0]     dur_q;
  logic [TW-1:0]        tick_q;
  logic [DUR_W-1:0]     dwell_q;
  logic [GW-1:0]        gap_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic                 arb_valid;
  logic [PW-1:0]        sel_idx;
  logic [2:0]           sel_color;
  logic [DUR_W-1:0]     sel_dur;
  logic [PW-1:0]        ptr_d;
  logic                 owner_req;
  logic                 show_last;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_rr (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Encode the one-hot pick and fetch that source's color, dwell and next pointer.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_idx = sel_idx | (arb_gnt[i] ? PW'(i) : PW'(0));
    end
    sel_color = bus.color[3*int'(sel_idx) +: 3];
    sel_dur   = bus.dur[DUR_W*int'(sel_idx) +: DUR_W];
    ptr_d     = (sel_idx == PW'(NUM_REQ - 1)) ? PW'(0) : sel_idx + PW'(1);
  end

  // Abort when the owner drops its request; the dwell ends on the last tick
  // of the last dwell unit. The dwell counter tops out at dur-1, so a
  // full-scale dur never wraps it. dur=0 ends after its single SHOW cycle.
  always_comb begin
    owner_req = |(bus.req & grant_q);
    show_last = (dur_q == '0) ||
                ((tick_q == TICK_LAST) && (dwell_q == (dur_q - DUR_W'(1))));
  end

  // Arbiter FSM with registered outputs, counters and color/dwell latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      rgb_q   <= LED_OFF;
      color_q <= '0;
      dur_q   <= '0;
      tick_q  <= '0;
      dwell_q <= '0;
      gap_q   <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            state_q <= SHOW;
            grant_q <= arb_gnt;
            busy_q  <= 1'b1;
            ptr_q   <= ptr_d;
            color_q <= rgb_t'(sel_color);
            dur_q   <= sel_dur;
            tick_q  <= '0;
            dwell_q <= '0;
            rgb_q   <= (sel_dur == '0) ? LED_OFF : led_drive(rgb_t'(sel_color));
          end else begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            rgb_q   <= LED_OFF;
          end
        end

        SHOW: begin
          if (!owner_req) begin
            // Abort wins even on the final dwell cycle: no done pulse.
            state_q <= GAP;
            grant_q <= '0;
            rgb_q   <= LED_OFF;
            gap_q   <= '0;
          end else if (show_last) begin
            state_q <= GAP;
            done_q  <= grant_q;
            grant_q <= '0;
            rgb_q   <= LED_OFF;
            gap_q   <= '0;
          end else begin
            rgb_q <= led_drive(color_q);
            if (tick_q == TICK_LAST) begin
              tick_q  <= '0;
              dwell_q <= dwell_q + DUR_W'(1);
            end else begin
              tick_q <= tick_q + TW'(1);
            end
          end
        end

        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          rgb_q   <= LED_OFF;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.RGB_R = rgb_q[2];
  assign bus.RGB_G = rgb_q[1];
  assign bus.RGB_B = rgb_q[0];

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// tb_rgb_led_arbiter: directed scenarios plus randomized traffic, every
// cycle checked against a transaction-level model (remaining-cycle budgets
// per grant) of the LED sharing rules.
module tb_rgb_led_arbiter;
  import rgb_led_pkg::*;

  localparam int N  = 4;
  localparam int DW = 10;
  localparam int TC = 4;
  localparam int GC = 3;

  logic clk;
  logic reset;

  int n_tests;
  int n_fail;
  int done_cnt;
  int gcnt;
  int litcnt;
  int glog[$];
  logic [N-1:0] prev_grant;

  // model state: mode 0=idle,1=show,2=gap
  int m_mode;
  int m_rem;
  int m_owner;
  int m_ptr;
  logic [N-1:0] e_grant;
  logic [N-1:0] e_done;
  logic         e_busy;
  logic [2:0]   e_rgb;

  rgb_led_if #(.NUM_REQ(N), .DUR_W(DW)) bus ();

  rgb_led_arbiter #(
    .NUM_REQ     (N),
    .TICK_CYCLES (TC),
    .DUR_W       (DW),
    .GAP_CYCLES  (GC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  // free-running clock
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model over one clock edge using the inputs about to be sampled.
  task automatic model_step();
    int pick;
    int d;
    int i;
    logic [2:0] c;
    pick = -1;
    e_done = '0;
    if (reset) begin
      m_mode = 0; m_ptr = 0; m_rem = 0;
      e_grant = '0; e_busy = 1'b0; e_rgb = 3'b111;
    end else if (m_mode == 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (pick < 0 && bus.req[i]) pick = i;
      end
      if (pick >= 0) begin
        d = int'(bus.dur[pick*DW +: DW]);
        c = bus.color[pick*3 +: 3];
        m_owner = pick;
        m_ptr   = (pick + 1) % N;
        m_mode  = 1;
        m_rem   = (d == 0) ? 1 : d * TC;
        e_grant = '0;
        e_grant[pick] = 1'b1;
        e_busy  = 1'b1;
        e_rgb   = (d == 0) ? 3'b111 : ~c;
      end
    end else if (m_mode == 1) begin
      if (!bus.req[m_owner]) begin
        m_mode = 2; m_rem = GC; e_grant = '0; e_rgb = 3'b111;
      end else begin
        m_rem--;
        if (m_rem == 0) begin
          e_done[m_owner] = 1'b1;
          m_mode = 2; m_rem = GC; e_grant = '0; e_rgb = 3'b111;
        end
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        m_mode = 0; e_busy = 1'b0;
      end
    end
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    check_eq("grant", 32'(bus.grant), 32'(e_grant));
    check_eq("done",  32'(bus.done),  32'(e_done));
    check_eq("busy",  32'(bus.busy),  32'(e_busy));
    check_eq("rgb",   32'({bus.RGB_R, bus.RGB_G, bus.RGB_B}), 32'(e_rgb));
    if (bus.done != '0) done_cnt++;
    if (bus.grant != '0) gcnt++;
    if ({bus.RGB_R, bus.RGB_G, bus.RGB_B} != 3'b111) litcnt++;
    if (bus.grant != '0 && prev_grant == '0) begin
      for (int k = 0; k < N; k++) if (bus.grant[k]) glog.push_back(k);
    end
    prev_grant = bus.grant;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_grant(input int budget);
    for (int k = 0; k < budget; k++) begin
      step();
      if (bus.grant != '0) break;
    end
    check_eq("wait_grant", 32'(bus.grant != '0), 32'd1);
  endtask

  task automatic clear_stats();
    glog.delete();
    done_cnt = 0;
    gcnt = 0;
    litcnt = 0;
  endtask

  initial begin
    int rr_exp[5];
    int cnt;
    int s;
    rr_exp = '{0, 1, 2, 3, 0};
    n_tests = 0; n_fail = 0;
    prev_grant = '0;
    clear_stats();
    reset = 1'b1;
    bus.req = '0; bus.color = '0; bus.dur = '0;
    repeat (3) step();
    reset = 1'b0;

    // reset state holds with no requests
    repeat (50) step();
    check_eq("idle_grants", 32'(gcnt), 32'd0);

    // single request: color 110, dur 2
    clear_stats();
    bus.color[2:0] = 3'b110;
    bus.dur[DW-1:0] = 10'd2;
    bus.req = 4'b0001;
    repeat (11) step();
    bus.req = 4'b0000;
    repeat (4) step();
    check_eq("single_done", 32'(done_cnt), 32'd1);
    check_eq("single_len", 32'(gcnt), 32'd8);
    check_eq("single_lit", 32'(litcnt), 32'd8);
    check_eq("single_grants", 32'(glog.size()), 32'd1);

    // round-robin with all requests held
    do_reset();
    clear_stats();
    for (int i = 0; i < N; i++) begin
      bus.dur[i*DW +: DW] = 10'd1;
      bus.color[i*3 +: 3] = 3'(i + 1);
    end
    bus.req = 4'b1111;
    repeat (42) step();
    bus.req = 4'b0000;
    repeat (10) step();
    check_eq("rr_count", 32'(glog.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++)
      check_eq("rr_order", 32'((k < glog.size()) ? glog[k] : 99), 32'(rr_exp[k]));

    // abort of source 0 two cycles into a dur=3 SHOW
    do_reset();
    clear_stats();
    for (int i = 0; i < N; i++) bus.dur[i*DW +: DW] = 10'd3;
    bus.req = 4'b0011;
    wait_grant(5);
    step();
    bus.req[0] = 1'b0;
    step();
    check_eq("abort_grant", 32'(bus.grant), 32'd0);
    repeat (10) step();
    check_eq("abort_done", 32'(done_cnt), 32'd0);
    check_eq("abort_next", 32'((glog.size() >= 2) ? glog[1] : 99), 32'd1);
    bus.req = 4'b0000;
    repeat (8) step();

    // dur=0: one dark SHOW cycle then done
    do_reset();
    clear_stats();
    bus.color[2:0] = 3'b111;
    bus.dur[DW-1:0] = 10'd0;
    bus.req = 4'b0001;
    repeat (4) step();
    bus.req = 4'b0000;
    repeat (4) step();
    check_eq("dur0_done", 32'(done_cnt), 32'd1);
    check_eq("dur0_len", 32'(gcnt), 32'd1);
    check_eq("dur0_lit", 32'(litcnt), 32'd0);

    // dur=1023: done exactly 1023*4 cycles after grant
    do_reset();
    clear_stats();
    bus.color[2:0] = 3'b010;
    bus.dur[DW-1:0] = 10'd1023;
    bus.req = 4'b0001;
    wait_grant(5);
    cnt = 0;
    for (int k = 0; k < 5000; k++) begin
      step();
      cnt++;
      if (bus.done[0]) break;
    end
    check_eq("dur_max_len", 32'(cnt), 32'd4092);
    bus.req = 4'b0000;
    repeat (8) step();

    // reset in the middle of SHOW restores pointer 0
    do_reset();
    clear_stats();
    bus.dur[DW-1:0] = 10'd3;
    bus.req = 4'b0001;
    wait_grant(5);
    repeat (2) step();
    reset = 1'b1;
    step();
    check_eq("mid_reset_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    bus.req = 4'b0011;
    step();
    check_eq("mid_reset_ptr", 32'(bus.grant), 32'd1);
    bus.req = 4'b0000;
    repeat (16) step();

    // randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        s = $urandom_range(0, N - 1);
        bus.req[s] = ~bus.req[s];
      end
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, N - 1);
        bus.color[s*3 +: 3] = 3'($urandom_range(0, 7));
        bus.dur[s*DW +: DW] = DW'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 799) == 0);
      step();
    end
    reset = 1'b0;
    bus.req = 4'b0000;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
